// File: rtl/demux_pkg.sv
// Shared widths and types for the 1-to-8 word demultiplexer.
package demux_pkg;

  localparam int DATA_W = 11;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;

endpackage

// File: rtl/chan_fifo2.sv
// Two-entry output channel FIFO. The head is always mem[rd_ptr]; a push into
// an empty FIFO only becomes visible after the clock edge (no bypass).
module chan_fifo2
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              valid,
  output logic [DATA_W-1:0] head
);

  word_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count == 2'd2);
  assign valid   = (count != 2'd0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  // Storage write, pointer advance and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_11bit.sv
// Registered 1-to-8 demultiplexer: routes each accepted word into the
// 2-entry FIFO of the channel named by select and counts accepted words.
module demux_11bit
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  select,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CNT_W-1:0]  xfer_count
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push_en;
  word_t             head [NUM_CH];
  logic              accept;

  // Readiness depends only on registered occupancy of the addressed channel.
  assign in_ready = !full[select] && !reset;
  assign accept   = in_valid && in_ready;

  // One-hot push enable decoded from select.
  always_comb begin
    push_en = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      push_en[k] = accept && (select == sel_t'(k));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    chan_fifo2 u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_en[k]),
      .push_data (in_data),
      .pop       (out_ready[k]),
      .full      (full[k]),
      .valid     (out_valid[k]),
      .head      (head[k])
    );
  end

  assign out0 = head[0];
  assign out1 = head[1];
  assign out2 = head[2];
  assign out3 = head[3];
  assign out4 = head[4];
  assign out5 = head[5];
  assign out6 = head[6];
  assign out7 = head[7];

  // Accepted-word counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_11bit.sv
module tb_demux_11bit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic [2:0]  select;
  logic [10:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [15:0] xfer_count;
  logic [10:0] outs [8];

  int n_cmp = 0;
  int n_err = 0;

  // reference model: per-channel word queues and an accept counter
  logic [10:0] mq [8][$];
  int          mcnt = 0;

  demux_11bit dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .select     (select),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out5       (out5),
    .out6       (out6),
    .out7       (out7),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; model follows the same inputs, returns at negedge
  task automatic tick();
    bit acc;
    acc = in_valid && !reset && (mq[select].size() < 2);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 8; k++) mq[k].delete();
      mcnt = 0;
    end else begin
      for (int k = 0; k < 8; k++)
        if (out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      if (acc) begin
        mq[select].push_back(in_data);
        mcnt = (mcnt + 1) % 65536;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; select = 3'd2; in_data = 11'h123; out_ready = 8'h00;
    tick(); tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
    n_cmp++;
    if (out_valid !== 8'h00) begin n_err++; $display("FAIL reset_out_valid got=%h exp=00", out_valid); end
    n_cmp++;
    if (xfer_count !== 16'h0000) begin n_err++; $display("FAIL reset_xfer got=%h exp=0000", xfer_count); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (outs[k] !== 11'h000) begin n_err++; $display("FAIL reset_out%0d got=%h exp=000", k, outs[k]); end
    end
    tick();
  endtask

  task automatic test_routing();
    logic [10:0] w;
    out_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      w = 11'h001 << k;
      in_valid = 1'b1; select = 3'(k); in_data = w;
      tick();
      n_cmp++;
      if (out_valid[k] !== 1'b1 || outs[k] !== w) begin
        n_err++; $display("FAIL route_ch%0d got v=%b d=%h exp v=1 d=%h", k, out_valid[k], outs[k], w);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (xfer_count !== 16'd8) begin n_err++; $display("FAIL route_xfer got=%0d exp=8", xfer_count); end
    n_cmp++;
    if (out_valid !== 8'h00) begin n_err++; $display("FAIL route_drained got=%h exp=00", out_valid); end
  endtask

  task automatic test_full();
    out_ready = 8'hF7;
    in_valid = 1'b1; select = 3'd3; in_data = 11'h7FF; tick();
    in_data = 11'h155; tick();
    in_data = 11'h2AA;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_sel3 got=%b exp=0", in_ready); end
    in_valid = 1'b0; select = 3'd4;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_sel4 got=%b exp=1", in_ready); end
    in_valid = 1'b1; select = 3'd3;
    tick();
    n_cmp++;
    if (out3 !== 11'h7FF || out_valid[3] !== 1'b1) begin
      n_err++; $display("FAIL full_stall_head got v=%b d=%h exp v=1 d=7ff", out_valid[3], out3);
    end
    in_valid = 1'b0; out_ready = 8'hFF;
    tick();
    n_cmp++;
    if (out3 !== 11'h155 || out_valid[3] !== 1'b1) begin
      n_err++; $display("FAIL full_second got v=%b d=%h exp v=1 d=155", out_valid[3], out3);
    end
    tick();
    n_cmp++;
    if (out_valid[3] !== 1'b0) begin n_err++; $display("FAIL full_empty got=%b exp=0", out_valid[3]); end
    n_cmp++;
    if (xfer_count !== 16'(mcnt) || mcnt != 10) begin
      n_err++; $display("FAIL full_xfer got=%0d exp=10", xfer_count);
    end
  endtask

  task automatic test_stream();
    out_ready = 8'hFF;
    in_valid = 1'b1; select = 3'd5; in_data = 11'($urandom);
    tick();
    for (int i = 0; i < 100; i++) begin
      in_data = 11'($urandom);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid[5] !== 1'b1 || out5 !== mq[5][0]) begin
        n_err++;
        $display("FAIL stream_%0d got rdy=%b v=%b d=%h exp rdy=1 v=1 d=%h", i, in_ready, out_valid[5], out5, mq[5][0]);
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 8'h00) begin n_err++; $display("FAIL stream_drain got=%h exp=00", out_valid); end
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      select    = 3'($urandom_range(7));
      in_data   = 11'($urandom);
      out_ready = 8'($urandom);
      #1;
      exp_rdy = (mq[select].size() < 2);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL rnd_ready_%0d got=%b exp=%b", i, in_ready, exp_rdy);
      end
      tick();
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (out_valid[k] !== (mq[k].size() > 0)) begin
          n_err++; $display("FAIL rnd_valid_%0d_ch%0d got=%b exp=%b", i, k, out_valid[k], mq[k].size() > 0);
        end else if (mq[k].size() > 0 && outs[k] !== mq[k][0]) begin
          n_err++; $display("FAIL rnd_data_%0d_ch%0d got=%h exp=%h", i, k, outs[k], mq[k][0]);
        end
      end
      n_cmp++;
      if (xfer_count !== 16'(mcnt)) begin
        n_err++; $display("FAIL rnd_xfer_%0d got=%0d exp=%0d", i, xfer_count, mcnt);
      end
    end
    in_valid = 1'b0; out_ready = 8'hFF;
    tick(); tick();
  endtask

  task automatic test_midreset();
    out_ready = 8'h00;
    in_valid = 1'b1;
    select = 3'd0; in_data = 11'h011; tick(); in_data = 11'h022; tick();
    select = 3'd7; in_data = 11'h077; tick(); in_data = 11'h0EE; tick();
    n_cmp++;
    if (out_valid !== 8'h81) begin n_err++; $display("FAIL mrst_pre got=%h exp=81", out_valid); end
    reset = 1'b1; select = 3'd1; in_data = 11'h3C3;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 8'h00) begin n_err++; $display("FAIL mrst_valid got=%h exp=00", out_valid); end
    n_cmp++;
    if (xfer_count !== 16'd0) begin n_err++; $display("FAIL mrst_xfer got=%0d exp=0", xfer_count); end
    n_cmp++;
    if (out0 !== 11'h000 || out7 !== 11'h000 || out1 !== 11'h000) begin
      n_err++; $display("FAIL mrst_data got o0=%h o1=%h o7=%h exp 000", out0, out1, out7);
    end
    out_ready = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 8'h00) begin n_err++; $display("FAIL mrst_stale_%0d got=%h exp=00", i, out_valid); end
    end
  endtask

  task automatic test_wrap();
    out_ready = 8'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      select = 3'(i);
      in_data = 11'(i);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (xfer_count !== 16'd1) begin n_err++; $display("FAIL wrap_xfer got=%0d exp=1", xfer_count); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; select = '0; out_ready = '0;
    @(negedge clk);
    test_reset();
    test_routing();
    test_full();
    test_stream();
    test_random();
    test_midreset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
